speicher_arbiter: RTL

Shares one single-port memory between the CPU instruction-fetch port and the CPU data port. It accepts level requests from the CPU control unit (instruction read, data read, data write) and grants one access at a time. It drives the memory strobes and holds them until the memory acknowledges. It then returns a one-cycle completion pulse to the requester. It sits between the CPU top level and the memory/bus, and includes anti-starvation logic and a hung-access watchdog.

---
 rtl/speicher_arbiter_if.sv | 40 ++++
 rtl/speicher_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/speicher_arbiter_if.sv
// CPU-side and memory-side signal bundle for the shared single-port memory arbiter.
// master: the arbiter's view; slave: the CPU control unit and memory facing it.
interface speicher_arbiter_if;
    localparam int unsigned WORT_W = 32;

    logic              LeseInstruktion;
    logic [WORT_W-1:0] InstruktionAdresse;
    logic [WORT_W-1:0] Instruktion;
    logic              InstruktionGeladen;
    logic              LeseDaten;
    logic              SchreibeDaten;
    logic [WORT_W-1:0] DatenAdresse;
    logic [WORT_W-1:0] DatenRaus;
    logic [WORT_W-1:0] DatenRein;
    logic              DatenGeladen;
    logic              DatenGespeichert;
    logic [WORT_W-1:0] SpeicherAdresse;
    logic [WORT_W-1:0] SpeicherSchreibDaten;
    logic              SpeicherLesen;
    logic              SpeicherSchreiben;
    logic [WORT_W-1:0] SpeicherLeseDaten;
    logic              SpeicherFertig;
    logic              Fehler;

    modport master (
        input  LeseInstruktion, InstruktionAdresse, LeseDaten, SchreibeDaten,
               DatenAdresse, DatenRaus, SpeicherLeseDaten, SpeicherFertig,
        output Instruktion, InstruktionGeladen, DatenRein, DatenGeladen,
               DatenGespeichert, SpeicherAdresse, SpeicherSchreibDaten,
               SpeicherLesen, SpeicherSchreiben, Fehler
    );

    modport slave (
        output LeseInstruktion, InstruktionAdresse, LeseDaten, SchreibeDaten,
               DatenAdresse, DatenRaus, SpeicherLeseDaten, SpeicherFertig,
        input  Instruktion, InstruktionGeladen, DatenRein, DatenGeladen,
               DatenGespeichert, SpeicherAdresse, SpeicherSchreibDaten,
               SpeicherLesen, SpeicherSchreiben, Fehler
    );
endinterface

// File: rtl/speicher_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory,
// with a data-streak limit against fetch starvation and a hung-access watchdog.
module speicher_arbiter #(
    parameter int unsigned TIMEOUT        = 255,
    parameter int unsigned ZAEHLER_BREITE = 8,
    parameter int unsigned MAX_DATEN      = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    speicher_arbiter_if.master   bus
);
    localparam int unsigned WORT_W   = 32;
    localparam int unsigned STREAK_W = $clog2(MAX_DATEN + 1);

    typedef enum logic [2:0] {
        LEERLAUF,
        INSTR,
        DATEN_LESEN,
        DATEN_SCHREIBEN,
        FERTIG
    } zustand_t;

    zustand_t                  zustand_q, zustand_d;
    logic [WORT_W-1:0]         instr_q, instr_d;
    logic [WORT_W-1:0]         daten_q, daten_d;
    logic [WORT_W-1:0]         adr_q, adr_d;
    logic [WORT_W-1:0]         wdaten_q, wdaten_d;
    logic                      lesen_q, lesen_d;
    logic                      schreiben_q, schreiben_d;
    logic                      instr_geladen_q, instr_geladen_d;
    logic                      daten_geladen_q, daten_geladen_d;
    logic                      gespeichert_q, gespeichert_d;
    logic                      fehler_q, fehler_d;
    logic [ZAEHLER_BREITE-1:0] wd_q, wd_d;
    logic [STREAK_W-1:0]       streak_q, streak_d;

    logic                      daten_anf;
    logic                      instr_gewinnt;
    logic [ZAEHLER_BREITE-1:0] wd_inc;
    logic                      abbruch;
    logic [WORT_W-1:0]         lese_wert;

    assign daten_anf     = bus.LeseDaten | bus.SchreibeDaten;
    assign instr_gewinnt = bus.LeseInstruktion &
                           (~daten_anf | (streak_q == STREAK_W'(MAX_DATEN)));
    assign wd_inc        = wd_q + ZAEHLER_BREITE'(1);
    assign abbruch       = ~bus.SpeicherFertig & (wd_inc == ZAEHLER_BREITE'(TIMEOUT));
    // An aborted read returns zero so the CPU sees a defined word.
    assign lese_wert     = bus.SpeicherFertig ? bus.SpeicherLeseDaten : '0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand_q       <= LEERLAUF;
            instr_q         <= '0;
            daten_q         <= '0;
            adr_q           <= '0;
            wdaten_q        <= '0;
            lesen_q         <= 1'b0;
            schreiben_q     <= 1'b0;
            instr_geladen_q <= 1'b0;
            daten_geladen_q <= 1'b0;
            gespeichert_q   <= 1'b0;
            fehler_q        <= 1'b0;
            wd_q            <= '0;
            streak_q        <= '0;
        end else begin
            zustand_q       <= zustand_d;
            instr_q         <= instr_d;
            daten_q         <= daten_d;
            adr_q           <= adr_d;
            wdaten_q        <= wdaten_d;
            lesen_q         <= lesen_d;
            schreiben_q     <= schreiben_d;
            instr_geladen_q <= instr_geladen_d;
            daten_geladen_q <= daten_geladen_d;
            gespeichert_q   <= gespeichert_d;
            fehler_q        <= fehler_d;
            wd_q            <= wd_d;
            streak_q        <= streak_d;
        end
    end

    always_comb begin
        zustand_d       = zustand_q;
        instr_d         = instr_q;
        daten_d         = daten_q;
        adr_d           = adr_q;
        wdaten_d        = wdaten_q;
        lesen_d         = lesen_q;
        schreiben_d     = schreiben_q;
        instr_geladen_d = 1'b0;
        daten_geladen_d = 1'b0;
        gespeichert_d   = 1'b0;
        fehler_d        = fehler_q;
        wd_d            = wd_q;
        streak_d        = streak_q;

        unique case (zustand_q)
            LEERLAUF: begin
                if (instr_gewinnt) begin
                    zustand_d = INSTR;
                    adr_d     = bus.InstruktionAdresse;
                    lesen_d   = 1'b1;
                    streak_d  = '0;
                end else if (daten_anf) begin
                    adr_d = bus.DatenAdresse;
                    if (!bus.LeseInstruktion) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_W'(MAX_DATEN)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    // Simultaneous read and write is resolved as a write and flagged.
                    if (bus.SchreibeDaten) begin
                        zustand_d   = DATEN_SCHREIBEN;
                        wdaten_d    = bus.DatenRaus;
                        schreiben_d = 1'b1;
                        if (bus.LeseDaten) begin
                            fehler_d = 1'b1;
                        end
                    end else begin
                        zustand_d = DATEN_LESEN;
                        lesen_d   = 1'b1;
                    end
                end
            end
            INSTR, DATEN_LESEN, DATEN_SCHREIBEN: begin
                wd_d = wd_inc;
                if (bus.SpeicherFertig || abbruch) begin
                    zustand_d   = FERTIG;
                    lesen_d     = 1'b0;
                    schreiben_d = 1'b0;
                    if (abbruch) begin
                        fehler_d = 1'b1;
                    end
                    if (zustand_q == INSTR) begin
                        instr_d         = lese_wert;
                        instr_geladen_d = 1'b1;
                    end else if (zustand_q == DATEN_LESEN) begin
                        daten_d         = lese_wert;
                        daten_geladen_d = 1'b1;
                    end else begin
                        gespeichert_d   = 1'b1;
                    end
                end
            end
            FERTIG: begin
                zustand_d = LEERLAUF;
                wd_d      = '0;
            end
            default: begin
                zustand_d = LEERLAUF;
            end
        endcase
    end

    assign bus.Instruktion          = instr_q;
    assign bus.InstruktionGeladen   = instr_geladen_q;
    assign bus.DatenRein            = daten_q;
    assign bus.DatenGeladen         = daten_geladen_q;
    assign bus.DatenGespeichert     = gespeichert_q;
    assign bus.SpeicherAdresse      = adr_q;
    assign bus.SpeicherSchreibDaten = wdaten_q;
    assign bus.SpeicherLesen        = lesen_q;
    assign bus.SpeicherSchreiben    = schreiben_q;
    assign bus.Fehler               = fehler_q;

endmodule
